memory_stage: RTL and testbench

- Fourth pipeline stage. Sits directly downstream of the execute stage.
- Consumes the execute-stage pipeline registers: ALU result, store data, destination register, memory controls, branch flags and condition bits.
- Performs data-memory loads and stores over a req/ack bus with a timeout, resolves conditional branches, and drives the MW pipeline register into write-back.
- Raises mem_stall while a memory access is outstanding so the hazard unit can freeze the upstream stages.

---
 rtl/memory_stage_pkg.sv | 23 ++
 rtl/memory_stage_if.sv | 21 ++
 rtl/memory_stage_branch.sv | 22 ++
 rtl/memory_stage.sv | 158 +++++++++++++++
 tb/tb_memory_stage.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/memory_stage_pkg.sv
// Shared CPU definitions for the memory stage: FSM encoding, branch-type
// indices and word-alignment helpers.
package cpu_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

    // Bit positions of the branch-type flags inside a packed flag vector
    localparam int unsigned BR_BEQ = 0;
    localparam int unsigned BR_BNE = 1;
    localparam int unsigned BR_BGT = 2;
    localparam int unsigned BR_NUM = 3;

    localparam logic [1:0] WORD_ALIGN_MASK = 2'b11;

    function automatic logic word_misaligned(input logic [1:0] addr_lo);
        return (addr_lo & WORD_ALIGN_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/memory_stage_if.sv
// Data-memory req/ack bus between the memory stage (master) and the memory (slave).
interface memory_stage_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic [31:0]       dm_rdata;
    logic              dm_ack;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata,
        input  dm_rdata, dm_ack
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata,
        output dm_rdata, dm_ack
    );
endinterface

// File: rtl/memory_stage_branch.sv
// Combinational branch resolution; also used by the forwarding/hazard logic.
module branch_resolve
    import cpu_pkg::*;
(
    input  logic [BR_NUM-1:0] i_br_type,
    input  logic              i_zero,
    input  logic              i_sign,
    input  logic [31:0]       i_pc,
    input  logic [31:0]       i_offset,
    output logic              o_taken,
    output logic [31:0]       o_target
);
    // Word offset shifted to bytes; the top two offset bits fall off by design
    logic w_unused_offset_hi;

    assign w_unused_offset_hi = ^i_offset[31:30];

    assign o_taken  = (i_br_type[BR_BEQ] &  i_zero) |
                      (i_br_type[BR_BNE] & ~i_zero) |
                      (i_br_type[BR_BGT] &  i_sign);
    assign o_target = i_pc + {i_offset[29:0], 2'b00};
endmodule

// File: rtl/memory_stage.sv
// Fourth pipeline stage: data-memory access over a req/ack bus with timeout,
// branch resolution, and the MW pipeline register.
module memory_stage
    import cpu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned ADDR_W  = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [31:0]           ALUout,
    input  logic [31:0]           XM_RT,
    input  logic [4:0]            XM_RD,
    input  logic                  XM_MemToReg,
    input  logic                  XM_MemWrite,
    input  logic [31:0]           DX_PC,
    input  logic [31:0]           DX_offset,
    input  logic                  zero,
    input  logic                  sign,
    input  logic                  DX_beq,
    input  logic                  DX_bne,
    input  logic                  DX_bgt,
    memory_stage_if.master        dm,
    output logic                  mem_stall,
    output logic                  branch_taken,
    output logic [31:0]           branch_target,
    output logic                  bus_error,
    output logic [31:0]           MW_ALUout,
    output logic [31:0]           MW_MemData,
    output logic [4:0]            MW_RD,
    output logic                  MW_MemToReg
);
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    mem_state_t  r_state;
    mem_state_t  w_next;
    logic [7:0]  r_cnt;
    logic [31:0] r_rbuf;
    logic        r_err;
    logic        r_mis_err;

    logic        w_mem_op;
    logic        w_misaligned;
    logic        w_start;
    logic        w_ack;
    logic        w_timeout;
    logic        w_cap;
    logic [4:0]  w_cap_rd;
    logic [31:0] w_cap_data;

    assign w_mem_op     = XM_MemToReg | XM_MemWrite;
    assign w_misaligned = w_mem_op & word_misaligned(ALUout[1:0]);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_ack       = 1'b0;
        w_timeout   = 1'b0;
        w_cap       = 1'b0;
        w_cap_rd    = XM_RD;
        w_cap_data  = '0;
        mem_stall   = 1'b0;
        dm.dm_req   = 1'b0;
        dm.dm_we    = 1'b0;
        dm.dm_addr  = '0;
        dm.dm_wdata = '0;
        case (r_state)
            IDLE: begin
                if (en) begin
                    if (w_mem_op & ~w_misaligned) begin
                        // IDLE is also the reset state, so the early stall is masked by rst
                        mem_stall = ~rst;
                        w_start   = 1'b1;
                        w_next    = ACCESS;
                    end else begin
                        w_cap = 1'b1;
                        if (w_misaligned) w_cap_rd = '0;
                    end
                end
            end
            ACCESS: begin
                dm.dm_req   = 1'b1;
                dm.dm_we    = XM_MemWrite;
                dm.dm_addr  = ADDR_W'(ALUout);
                dm.dm_wdata = XM_RT;
                mem_stall   = 1'b1;
                if (dm.dm_ack) begin
                    w_ack  = 1'b1;
                    w_next = DONE;
                end else if (r_cnt == TO_LAST) begin
                    w_timeout = 1'b1;
                    w_next    = DONE;
                end
            end
            DONE: begin
                if (en) begin
                    w_cap      = 1'b1;
                    w_cap_data = r_rbuf;
                    if (r_err) w_cap_rd = '0;
                    w_next     = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_rbuf      <= '0;
            r_err       <= 1'b0;
            r_mis_err   <= 1'b0;
            MW_ALUout   <= '0;
            MW_MemData  <= '0;
            MW_RD       <= '0;
            MW_MemToReg <= 1'b0;
        end else begin
            r_mis_err <= (r_state == IDLE) & en & w_misaligned;
            if (w_start) begin
                r_cnt <= '0;
                r_err <= 1'b0;
            end else if (r_state == ACCESS) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (w_ack) begin
                r_rbuf <= dm.dm_rdata;
            end else if (w_timeout) begin
                r_rbuf <= '0;
                r_err  <= 1'b1;
            end
            if (w_cap) begin
                MW_ALUout   <= ALUout;
                MW_MemData  <= w_cap_data;
                MW_RD       <= w_cap_rd;
                MW_MemToReg <= XM_MemToReg;
            end
        end
    end

    // Misalignment reports one cycle late; timeout reports while DONE retires
    assign bus_error = r_mis_err | ((r_state == DONE) & en & r_err);

    branch_resolve u_branch (
        .i_br_type (DX_bgt ? 3'b100 | {1'b0, DX_bne, DX_beq} : {1'b0, DX_bne, DX_beq}),
        .i_zero    (zero),
        .i_sign    (sign),
        .i_pc      (DX_PC),
        .i_offset  (DX_offset),
        .o_taken   (branch_taken),
        .o_target  (branch_target)
    );
endmodule

// File: tb/tb_memory_stage.sv
// Randomized self-checking bench for memory_stage against a transaction-level model.
module tb_memory_stage;
    import cpu_pkg::*;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [31:0] ALUout, XM_RT, DX_PC, DX_offset;
    logic [4:0]  XM_RD;
    logic        XM_MemToReg, XM_MemWrite;
    logic        zero, sign, DX_beq, DX_bne, DX_bgt;
    logic        mem_stall, branch_taken, bus_error, MW_MemToReg;
    logic [31:0] branch_target, MW_ALUout, MW_MemData;
    logic [4:0]  MW_RD;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    // Expected MW contents after the most recent retired instruction
    logic [31:0] m_alu, m_data;
    logic [4:0]  m_rd;
    logic        m_ld;

    memory_stage_if #(.ADDR_W(32)) dm_if ();

    memory_stage #(.TIMEOUT(TO), .ADDR_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .en            (en),
        .ALUout        (ALUout),
        .XM_RT         (XM_RT),
        .XM_RD         (XM_RD),
        .XM_MemToReg   (XM_MemToReg),
        .XM_MemWrite   (XM_MemWrite),
        .DX_PC         (DX_PC),
        .DX_offset     (DX_offset),
        .zero          (zero),
        .sign          (sign),
        .DX_beq        (DX_beq),
        .DX_bne        (DX_bne),
        .DX_bgt        (DX_bgt),
        .dm            (dm_if.master),
        .mem_stall     (mem_stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .bus_error     (bus_error),
        .MW_ALUout     (MW_ALUout),
        .MW_MemData    (MW_MemData),
        .MW_RD         (MW_RD),
        .MW_MemToReg   (MW_MemToReg)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic check_mw(input string tag);
        check({tag, ".MW_ALUout"},   MW_ALUout,         m_alu);
        check({tag, ".MW_MemData"},  MW_MemData,        m_data);
        check({tag, ".MW_RD"},       32'(MW_RD),        32'(m_rd));
        check({tag, ".MW_MemToReg"}, 32'(MW_MemToReg),  32'(m_ld));
    endtask

    task automatic check_quiet(input string tag, input logic exp_stall);
        check({tag, ".dm_req"},    32'(dm_if.dm_req),   32'd0);
        check({tag, ".dm_we"},     32'(dm_if.dm_we),    32'd0);
        check({tag, ".dm_addr"},   dm_if.dm_addr,       32'd0);
        check({tag, ".mem_stall"}, 32'(mem_stall),      32'(exp_stall));
    endtask

    // Entered and left #1 after a rising edge. ack_at = cycle of dm_req in which
    // ack arrives (1-based); 0 means the memory never answers.
    task automatic run_txn(input logic [31:0] alu, input logic [31:0] rt, input logic [4:0] rd,
                           input logic ld, input logic st, input int unsigned ack_at,
                           input logic [31:0] rdata, input int unsigned idle_pre,
                           input int unsigned done_hold);
        logic        memop, mis, tmo;
        int unsigned reqc;
        memop = ld | st;
        mis   = memop && (alu % 4 != 0);
        ALUout = alu; XM_RT = rt; XM_RD = rd; XM_MemToReg = ld; XM_MemWrite = st;
        dm_if.dm_ack = 1'b0;
        en = 1'b0;
        for (int unsigned i = 0; i < idle_pre; i++) begin
            @(negedge clk);
            check_quiet("idle_en0", 1'b0);
            check_mw("idle_en0_hold");
            @(posedge clk); #1;
        end
        en = 1'b1;
        if (!memop || mis) begin
            @(negedge clk);
            check_quiet("single", 1'b0);
            check("single.bus_error", 32'(bus_error), 32'd0);
            m_alu = alu; m_data = 32'd0; m_rd = mis ? 5'd0 : rd; m_ld = ld;
            @(posedge clk); #1;
        end else begin
            tmo  = (ack_at == 0) || (ack_at > TO);
            reqc = tmo ? TO : ack_at;
            @(negedge clk);
            check_quiet("issue", 1'b1);
            for (int unsigned c = 1; c <= reqc; c++) begin
                @(posedge clk); #1;
                dm_if.dm_ack   = (c == ack_at);
                dm_if.dm_rdata = (c == ack_at) ? rdata : $urandom;
                @(negedge clk);
                check("acc.dm_req",    32'(dm_if.dm_req), 32'd1);
                check("acc.dm_we",     32'(dm_if.dm_we),  32'(st));
                check("acc.dm_addr",   dm_if.dm_addr,     alu);
                check("acc.dm_wdata",  dm_if.dm_wdata,    rt);
                check("acc.mem_stall", 32'(mem_stall),    32'd1);
                check("acc.MW_RD_hold", 32'(MW_RD),       32'(m_rd));
            end
            @(posedge clk); #1;
            dm_if.dm_ack = 1'b0;
            en = 1'b0;
            for (int unsigned i = 0; i < done_hold; i++) begin
                dm_if.dm_rdata = $urandom;
                @(negedge clk);
                check_quiet("done_en0", 1'b0);
                check("done_en0.bus_error", 32'(bus_error), 32'd0);
                check_mw("done_en0_hold");
                @(posedge clk); #1;
            end
            en = 1'b1;
            @(negedge clk);
            check_quiet("done", 1'b0);
            check("done.bus_error", 32'(bus_error), 32'(tmo));
            m_alu = alu; m_data = tmo ? 32'd0 : rdata; m_rd = tmo ? 5'd0 : rd; m_ld = ld;
            @(posedge clk); #1;
        end
        en = 1'b0; XM_MemToReg = 1'b0; XM_MemWrite = 1'b0;
        check_mw("retire");
        @(negedge clk);
        check("after.bus_error", 32'(bus_error), 32'(mis));
        check_quiet("after", 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic branch_case(input logic beq, input logic bne, input logic bgt,
                               input logic z, input logic s,
                               input logic [31:0] pc, input logic [31:0] off);
        logic        exp_taken;
        logic [31:0] exp_target;
        DX_beq = beq; DX_bne = bne; DX_bgt = bgt; zero = z; sign = s;
        DX_PC = pc; DX_offset = off;
        #1;
        exp_taken  = (beq && z) || (bne && !z) || (bgt && s);
        exp_target = pc + off * 32'd4;
        check("branch_taken",  32'(branch_taken), 32'(exp_taken));
        check("branch_target", branch_target,     exp_target);
    endtask

    initial begin
        logic [31:0] alu;
        int unsigned kind, ack;
        logic        ld, st;

        rst = 1'b1; en = 1'b1;
        ALUout = 32'h100; XM_RT = '0; XM_RD = 5'd3; XM_MemToReg = 1'b1; XM_MemWrite = 1'b0;
        DX_PC = '0; DX_offset = '0; zero = 1'b0; sign = 1'b0;
        DX_beq = 1'b0; DX_bne = 1'b0; DX_bgt = 1'b0;
        dm_if.dm_ack = 1'b0; dm_if.dm_rdata = '0;
        m_alu = '0; m_data = '0; m_rd = '0; m_ld = 1'b0;
        #3;
        check_quiet("reset", 1'b0);
        check("reset.bus_error", 32'(bus_error), 32'd0);
        check_mw("reset");
        @(negedge clk);
        rst = 1'b0; en = 1'b0; XM_MemToReg = 1'b0;
        @(posedge clk); #1;

        // Directed cases from the bring-up plan
        run_txn(32'h10,  32'h0,         5'd5, 1'b0, 1'b0, 0,  32'h0,         0, 0);
        run_txn(32'h100, 32'h0,         5'd8, 1'b1, 1'b0, 3,  32'hDEAD_BEEF, 0, 0);
        run_txn(32'h20,  32'h1234_5678, 5'd9, 1'b0, 1'b1, 1,  32'h0BAD_F00D, 1, 0);
        run_txn(32'h40,  32'h0,         5'd7, 1'b1, 1'b0, 0,  32'h0,         0, 2);
        run_txn(32'h44,  32'h0,         5'd6, 1'b1, 1'b0, TO, 32'hCAFE_0001, 0, 1);
        run_txn(32'h102, 32'h0,         5'd4, 1'b1, 1'b0, 1,  32'h0,         0, 0);

        branch_case(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h40, 32'hFFFF_FFFE);
        branch_case(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h40, 32'hFFFF_FFFE);
        branch_case(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0000_0002);
        for (int i = 0; i < 30; i++)
            branch_case(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                        1'($urandom), $urandom, $urandom);

        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 3);
            ack  = $urandom_range(1, TO + 1);
            if (ack == TO + 1) ack = 0;
            alu  = $urandom;
            ld = 1'b0; st = 1'b0;
            case (kind)
                1: begin ld = 1'b1; alu[1:0] = 2'b00; end
                2: begin st = 1'b1; alu[1:0] = 2'b00; end
                3: begin
                    if ($urandom_range(0, 1) == 0) ld = 1'b1; else st = 1'b1;
                    alu[1:0] = 2'($urandom_range(1, 3));
                end
                default: ;
            endcase
            run_txn(alu, $urandom, 5'($urandom), ld, st, ack, $urandom,
                    $urandom_range(0, 2), $urandom_range(0, 2));
        end

        // Asynchronous reset in the middle of a load
        ALUout = 32'h200; XM_RD = 5'd12; XM_MemToReg = 1'b1; XM_MemWrite = 1'b0; en = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        check("rst_mid.dm_req_before", 32'(dm_if.dm_req), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rst_mid.dm_req",    32'(dm_if.dm_req), 32'd0);
        check("rst_mid.mem_stall", 32'(mem_stall),    32'd0);
        #1 rst = 1'b0; en = 1'b0;
        dm_if.dm_ack = 1'b1; dm_if.dm_rdata = 32'h5555_AAAA;
        m_alu = '0; m_data = '0; m_rd = '0; m_ld = 1'b0;
        @(posedge clk); #1;
        dm_if.dm_ack = 1'b0;
        check_mw("rst_mid_late_ack");
        @(negedge clk);
        check_quiet("rst_mid_after", 1'b0);
        check("rst_mid.bus_error", 32'(bus_error), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
